// File: rtl/vram_pkg.sv
// vram_pkg: register selects, control opcodes, FSM states, request record and default geometry for the VRAM port-A controller
package vram_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_PTRL = 2'd1;
  localparam logic [1:0] REG_PTRH = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam logic [3:0] OP_MODE = 4'h0;
  localparam logic [3:0] OP_BASELO = 4'h1;
  localparam logic [3:0] OP_BASEHI = 4'h2;
  localparam int CLEAR_LEN_DEF = 38400;
  localparam int LINE_BYTES_DEF = 80;
  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_PF_ISSUE, ST_PF_LATCH, ST_CLEAR} state_t;
  typedef struct packed {
    logic       wr;
    logic [1:0] sel;
    logic [7:0] data;
  } req_t;
endpackage

// File: rtl/vram_req_slot.sv
// vram_req_slot: one-deep CPU request holder; in clk/resetn/wr_stb/rd_stb/reg_sel/wr_data/pop, out full/req/ovf_set (strobe dropped this cycle)
module vram_req_slot
  import vram_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [1:0] reg_sel,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic       full,
  output req_t       req,
  output logic       ovf_set
);
  assign ovf_set = (wr_stb && rd_stb) || (full && (wr_stb || rd_stb));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full <= 1'b0;
      req  <= '0;
    end else if (!full && (wr_stb || rd_stb)) begin
      full <= 1'b1;
      req  <= '{wr: wr_stb, sel: reg_sel, data: wr_data};
    end else if (pop) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/vram_access_ctrl.sv
// vram_access_ctrl: CPU-side BRAM port A sequencer; CPU strobes/reg_sel/wr_data/rd_data, BRAM port A (ada/dina/wrea/cea/douta), lock, videomode, screenbase, busy, overrun
module vram_access_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int CLEAR_LEN  = CLEAR_LEN_DEF,
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int BASE_W     = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_stb,
  input  logic              rd_stb,
  input  logic [1:0]        reg_sel,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] bram_ada,
  output logic [7:0]        bram_dina,
  output logic              bram_wrea,
  output logic              bram_cea,
  input  logic [7:0]        bram_douta,
  output logic              bram_lock,
  output logic              videomode,
  output logic [BASE_W-1:0] screenbase,
  output logic              busy,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLEAR_LEN - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [7:0] pf, pf_n, wdata, wdata_n, base, base_n;
  logic mode_n, pop, full, ovf_set, wr_cyc, ovf_clr;
  logic [BASE_W-1:0] sb_n;
  req_t req;
  vram_req_slot u_slot (
    .clk    (clk),
    .resetn (resetn),
    .wr_stb (wr_stb),
    .rd_stb (rd_stb),
    .reg_sel(reg_sel),
    .wr_data(wr_data),
    .pop    (pop),
    .full   (full),
    .req    (req),
    .ovf_set(ovf_set)
  );
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    pf_n    = pf;
    wdata_n = wdata;
    mode_n  = videomode;
    base_n  = base;
    sb_n    = screenbase;
    pop     = 1'b0;
    case (state)
      ST_IDLE: if (full) begin
        pop = 1'b1;
        if (req.wr) begin
          case (req.sel)
            REG_DATA: begin
              wdata_n = req.data;
              state_n = ST_WRITE;
            end
            REG_PTRL: ptr_n[7:0] = req.data;
            REG_PTRH: begin
              ptr_n[ADDR_W-1:8] = req.data[ADDR_W-9:0];
              state_n = ST_PF_ISSUE;
            end
            default: begin
              if (req.data[7:4] == OP_MODE) begin
                mode_n  = req.data[0];
                ptr_n   = '0;
                state_n = ST_CLEAR;
              end
              if (req.data[7:4] == OP_BASELO) base_n[3:0] = req.data[3:0];
              if (req.data[7:4] == OP_BASEHI) begin
                base_n[7:4] = req.data[3:0];
                sb_n = BASE_W'(LINE_BYTES * int'(base_n));
              end
            end
          endcase
        end else if (req.sel == REG_DATA && !videomode) begin
          // text-mode read-complete advances to the next byte and refills the prefetch latch
          ptr_n   = ptr + 1'b1;
          state_n = ST_PF_ISSUE;
        end
      end
      ST_WRITE: begin
        ptr_n   = ptr + 1'b1;
        state_n = ST_IDLE;
      end
      ST_PF_ISSUE: state_n = ST_PF_LATCH;
      ST_PF_LATCH: begin
        pf_n    = bram_douta;
        state_n = ST_IDLE;
      end
      ST_CLEAR: begin
        ptr_n   = (ptr == LAST) ? '0 : ptr + 1'b1;
        state_n = (ptr == LAST) ? ST_IDLE : ST_CLEAR;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  // a write strobe alongside the reg3 read still records its own drop
  assign ovf_clr = rd_stb && !wr_stb && reg_sel == REG_CTRL;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      pf         <= '0;
      wdata      <= '0;
      videomode  <= 1'b0;
      base       <= '0;
      screenbase <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      pf         <= pf_n;
      wdata      <= wdata_n;
      videomode  <= mode_n;
      base       <= base_n;
      screenbase <= sb_n;
      overrun    <= ovf_clr ? 1'b0 : (ovf_set ? 1'b1 : overrun);
    end
  end
  assign wr_cyc    = state == ST_WRITE || state == ST_CLEAR;
  assign bram_wrea = wr_cyc;
  assign bram_lock = wr_cyc;
  assign bram_cea  = wr_cyc || state == ST_PF_ISSUE;
  assign bram_ada  = bram_cea ? ptr : '0;
  assign bram_dina = state == ST_WRITE ? wdata : 8'h00;
  assign busy      = state != ST_IDLE || full;
  assign rd_data   = reg_sel == REG_DATA ? pf :
                     reg_sel == REG_PTRL ? ptr[7:0] :
                     reg_sel == REG_PTRH ? 8'(ptr >> 8) :
                     {overrun, 5'b0, busy, videomode};
endmodule
